// File: rtl/arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arbiter_pkg
// Shared definitions for the round-robin stream merger and its picker.
//   state_t     : arbiter FSM state (IDLE, GRANT)
//   clog2()     : ceiling log2 usable in parameter expressions
//   idw()       : width of a requester index, never below 1 bit
//   cw()        : width of the per-grant beat counter, never below 1 bit
// -----------------------------------------------------------------------------
package arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int idw(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int cw(input int b);
    return (clog2(b) < 1) ? 1 : clog2(b);
  endfunction

endpackage

// File: rtl/rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Combinational rotate-priority picker. Scans i_ptr+1, i_ptr+2, ... (mod N)
// and ends at i_ptr itself; the first requesting index wins.
// Ports:
//   i_req      [N-1:0]  request vector
//   i_ptr      [PW-1:0] last-served index (search starts just after it)
//   i_mask_ptr          drop the request at i_ptr from the search
//   o_idx      [PW-1:0] winning index (i_ptr when nothing requests)
//   o_valid             at least one (unmasked) request present
// -----------------------------------------------------------------------------
module rr_select
  import arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = idw(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  input  logic          i_mask_ptr,
  output logic [PW-1:0] o_idx,
  output logic          o_valid
);

  logic [N-1:0]  w_req;
  logic          w_found_hi;
  logic          w_found_lo;
  logic [PW-1:0] w_idx_hi;
  logic [PW-1:0] w_idx_lo;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_req[i] = i_req[i] & ~(i_mask_ptr & (i_ptr == PW'(i)));
    end
  end

  // Rotation done as two ascending scans: indices above the pointer first,
  // then wrap around to 0..pointer. Avoids modulo arithmetic on the index.
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_idx_hi   = '0;
    w_idx_lo   = '0;
    for (int i = 0; i < N; i++) begin
      if (!w_found_hi && w_req[i] && (PW'(i) > i_ptr)) begin
        w_found_hi = 1'b1;
        w_idx_hi   = PW'(i);
      end
      if (!w_found_lo && w_req[i] && (PW'(i) <= i_ptr)) begin
        w_found_lo = 1'b1;
        w_idx_lo   = PW'(i);
      end
    end
  end

  assign o_valid = |w_req;
  assign o_idx   = w_found_hi ? w_idx_hi : (w_found_lo ? w_idx_lo : i_ptr);

endmodule

// File: rtl/arbiter_rr.sv
// -----------------------------------------------------------------------------
// arbiter_rr
// Round-robin N-to-1 stream merger on the stb/rdy datapath. One producer is
// granted at a time for up to B consecutive beats; the merged stream leaves
// through a single output register.
//
// Handshake: a beat moves on a port in every cycle where its strobe and its
// ready are both high at the clock edge. Strobe/data must stay stable while
// ready is low; ready may depend combinationally on the opposite side only
// through m_rdy (s_rdy never depends on s_stb).
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   s_stb   [N-1:0]     per-slave strobe
//   s_dat   [N*W-1:0]   slave data, slave i in [i*W +: W]
//   s_rdy   [N-1:0]     per-slave ready, zero or one-hot
//   m_rdy               downstream ready
//   m_stb               registered master strobe
//   m_dat   [W-1:0]     registered master data
//   m_id    [IDW-1:0]   source index of the beat in m_dat
//                       (only when ARBITER_RR_ID_EN is defined)
//   dbg_state           current FSM state, for observation only
// -----------------------------------------------------------------------------
module arbiter_rr
  import arbiter_pkg::*;
#(
  parameter  int W   = 8,
  parameter  int N   = 2,
  parameter  int B   = 1,
  localparam int IDW = idw(N),
  localparam int CW  = cw(B)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   s_stb,
  input  logic [N*W-1:0] s_dat,
  output logic [N-1:0]   s_rdy,
  input  logic           m_rdy,
  output logic           m_stb,
  output logic [W-1:0]   m_dat,
`ifdef ARBITER_RR_ID_EN
  output logic [IDW-1:0] m_id,
`endif
  output state_t         dbg_state
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_g;
  logic [IDW-1:0]   w_g_nxt;
  logic [CW-1:0]    r_c;
  logic [CW-1:0]    w_c_nxt;

  logic             r_m_stb;
  logic [W-1:0]     r_m_dat;
`ifdef ARBITER_RR_ID_EN
  logic [IDW-1:0]   r_m_id;
`endif

  logic             w_free;
  logic             w_beat;
  logic             w_last;
  logic             w_g_stb;
  logic [W-1:0]     w_sel_dat;
  logic [IDW-1:0]   w_pick_idx;
  logic             w_pick_valid;

  // Output register can take a new beat when empty or draining this cycle.
  assign w_free = ~r_m_stb | m_rdy;
  assign w_last = (r_c == CW'(B - 1));

  always_comb begin
    w_g_stb   = 1'b0;
    w_sel_dat = '0;
    for (int i = 0; i < N; i++) begin
      if (r_g == IDW'(i)) begin
        w_g_stb   = s_stb[i];
        w_sel_dat = s_dat[i*W +: W];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      s_rdy[i] = (r_state == GRANT) && (r_g == IDW'(i)) && w_free;
    end
  end

  assign w_beat = (r_state == GRANT) & w_free & w_g_stb;

  // The current holder is masked only when it just moved a beat; if nobody
  // else requests, o_valid drops and the holder simply keeps the grant.
  rr_select #(
    .N  (N),
    .PW (IDW)
  ) u_sel (
    .i_req      (s_stb),
    .i_ptr      (r_g),
    .i_mask_ptr (w_beat),
    .o_idx      (w_pick_idx),
    .o_valid    (w_pick_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_g_nxt     = r_g;
    w_c_nxt     = r_c;
    case (r_state)
      IDLE: begin
        // No slave is accepted here: one bubble cycle after idle.
        if (w_pick_valid) begin
          w_g_nxt     = w_pick_idx;
          w_c_nxt     = '0;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!w_g_stb) begin
          // Holder forfeits; no beat from it this cycle.
          w_c_nxt = '0;
          if (w_pick_valid) begin
            w_g_nxt = w_pick_idx;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_beat && w_last) begin
          // Burst quota used up: rotate if anyone else waits.
          w_c_nxt = '0;
          if (w_pick_valid) begin
            w_g_nxt = w_pick_idx;
          end
        end else if (w_beat) begin
          w_c_nxt = r_c + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_g     <= IDW'(N - 1);
      r_c     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_g     <= w_g_nxt;
      r_c     <= w_c_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_stb <= 1'b0;
      r_m_dat <= '0;
`ifdef ARBITER_RR_ID_EN
      r_m_id  <= '0;
`endif
    end else if (w_beat) begin
      r_m_stb <= 1'b1;
      r_m_dat <= w_sel_dat;
`ifdef ARBITER_RR_ID_EN
      r_m_id  <= r_g;
`endif
    end else if (m_rdy) begin
      r_m_stb <= 1'b0;
    end
  end

  assign m_stb     = r_m_stb;
  assign m_dat     = r_m_dat;
`ifdef ARBITER_RR_ID_EN
  assign m_id      = r_m_id;
`endif
  assign dbg_state = r_state;

endmodule

// File: tb/tb_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_arbiter_rr
// Four arbiter instances with different shapes, exercised one at a time:
//   d0: N=2 B=1   d1: N=3 B=1   d2: N=2 B=4   d3: N=4 B=1
// Slave data encodes {slave index, per-slave sequence number}. Accepted slave
// beats are pushed to exp_q and popped when the master side delivers a beat.
// The required grant order for each scenario is pushed to src_q up front.
// -----------------------------------------------------------------------------
module tb_arbiter_rr;
  import arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [3:0]  s_stb [4];
  logic [31:0] s_dat [4];
  logic [3:0]  s_rdy [4];
  logic [3:0]  m_rdy;
  logic [3:0]  m_stb;
  logic [7:0]  m_dat [4];
  state_t      dbg_st [4];
  logic [1:0]  w_rdy0;
  logic [2:0]  w_rdy1;
  logic [1:0]  w_rdy2;
  logic [3:0]  w_rdy3;
`ifdef ARBITER_RR_ID_EN
  logic [0:0]  m_id0;
  logic [1:0]  m_id1;
  logic [0:0]  m_id2;
  logic [1:0]  m_id3;
`endif

  assign s_rdy[0] = {2'b00, w_rdy0};
  assign s_rdy[1] = {1'b0, w_rdy1};
  assign s_rdy[2] = {2'b00, w_rdy2};
  assign s_rdy[3] = w_rdy3;

  arbiter_rr #(.W(8), .N(2), .B(1)) u_d0 (
    .clk(clk), .rst(rst), .s_stb(s_stb[0][1:0]), .s_dat(s_dat[0][15:0]),
    .s_rdy(w_rdy0), .m_rdy(m_rdy[0]), .m_stb(m_stb[0]), .m_dat(m_dat[0]),
`ifdef ARBITER_RR_ID_EN
    .m_id(m_id0),
`endif
    .dbg_state(dbg_st[0]));

  arbiter_rr #(.W(8), .N(3), .B(1)) u_d1 (
    .clk(clk), .rst(rst), .s_stb(s_stb[1][2:0]), .s_dat(s_dat[1][23:0]),
    .s_rdy(w_rdy1), .m_rdy(m_rdy[1]), .m_stb(m_stb[1]), .m_dat(m_dat[1]),
`ifdef ARBITER_RR_ID_EN
    .m_id(m_id1),
`endif
    .dbg_state(dbg_st[1]));

  arbiter_rr #(.W(8), .N(2), .B(4)) u_d2 (
    .clk(clk), .rst(rst), .s_stb(s_stb[2][1:0]), .s_dat(s_dat[2][15:0]),
    .s_rdy(w_rdy2), .m_rdy(m_rdy[2]), .m_stb(m_stb[2]), .m_dat(m_dat[2]),
`ifdef ARBITER_RR_ID_EN
    .m_id(m_id2),
`endif
    .dbg_state(dbg_st[2]));

  arbiter_rr #(.W(8), .N(4), .B(1)) u_d3 (
    .clk(clk), .rst(rst), .s_stb(s_stb[3]), .s_dat(s_dat[3]),
    .s_rdy(w_rdy3), .m_rdy(m_rdy[3]), .m_stb(m_stb[3]), .m_dat(m_dat[3]),
`ifdef ARBITER_RR_ID_EN
    .m_id(m_id3),
`endif
    .dbg_state(dbg_st[3]));

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard state ----------------
  logic [11:0] exp_q [$];   // {dut, source, data}
  logic [1:0]  src_q [$];   // required grant order of slave beats
  int          seq [4][4];
  int          lim [4][4];
  logic [3:0]  beat [4];
  logic [3:0]  mrdy_ctl;
  logic        fixed_mode;
  int          cyc = 0;
  int          d_act = 0;
  int          bcnt, first_cyc, last_cyc, start_cyc;

  function automatic int n_of(input int d);
    case (d)
      0:       return 2;
      1:       return 3;
      2:       return 2;
      default: return 4;
    endcase
  endfunction

  // ---------------- driver / monitor ----------------
  initial begin
    logic [11:0] e;
    for (int d = 0; d < 4; d++) begin
      beat[d]  = '0;
      s_stb[d] = '0;
      s_dat[d] = '0;
      for (int i = 0; i < 4; i++) begin
        seq[d][i] = 0;
        lim[d][i] = 0;
      end
    end
    m_rdy = 4'hF;
    forever begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 4; d++) begin
        m_rdy[d] = mrdy_ctl[d];
        for (int i = 0; i < 4; i++) begin
          if (beat[d][i]) seq[d][i]++;
          s_stb[d][i] = (i < n_of(d)) && (seq[d][i] < lim[d][i]);
          s_dat[d][i*8 +: 8] = fixed_mode ? {4'(10 + i), 4'(i)} : {4'(i), 4'(seq[d][i])};
        end
      end
      #1;
      for (int d = 0; d < 4; d++) begin
        check("rdy_onehot0", {31'd0, $onehot0(s_rdy[d])}, 32'd1);
        beat[d] = s_stb[d] & s_rdy[d];
        for (int i = 0; i < 4; i++) begin
          if (beat[d][i]) begin
            exp_q.push_back({2'(d), 2'(i), s_dat[d][i*8 +: 8]});
            if (src_q.size() == 0) check("src_extra_beat", 32'(src_q.size()), 32'd1);
            else check("src_order", 32'(i), {30'd0, src_q.pop_front()});
            if (d == d_act) begin
              bcnt++;
              if (first_cyc < 0) first_cyc = cyc;
              last_cyc = cyc;
            end
          end
        end
        if (m_stb[d] && m_rdy[d]) begin
          if (exp_q.size() == 0) check("m_extra_beat", 32'(exp_q.size()), 32'd1);
          else begin
            e = exp_q.pop_front();
            check("m_dat", {22'd0, 2'(d), m_dat[d]}, {22'd0, e[11:10], e[7:0]});
`ifdef ARBITER_RR_ID_EN
            if (d == 3) check("m_id", {30'd0, m_id3}, {30'd0, e[9:8]});
`endif
          end
        end
      end
    end
  end

  // ---------------- helper tasks ----------------
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic stop_all();
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < 4; i++) lim[d][i] = 0;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    stop_all();
    exp_q.delete();
    src_q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic begin_test(input int d);
    d_act     = d;
    bcnt      = 0;
    first_cyc = -1;
    last_cyc  = -1;
    start_cyc = cyc;
  endtask

  task automatic set_lim(input int d, input int i, input int cnt);
    lim[d][i] = seq[d][i] + cnt;
  endtask

  task automatic wait_done(input int max_cyc);
    for (int k = 0; k < max_cyc; k++) begin
      if (src_q.size() == 0 && exp_q.size() == 0 && s_stb[d_act] == 4'd0) break;
      tick();
    end
    repeat (3) tick();
    check("drain_src_q", 32'(src_q.size()), 32'd0);
    check("drain_exp_q", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_timing(input string tag, input int span, input int beats);
    check({tag, "_first"}, 32'(first_cyc - start_cyc), 32'd2);
    check({tag, "_span"},  32'(last_cyc - first_cyc), 32'(span));
    check({tag, "_beats"}, 32'(bcnt), 32'(beats));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int base;
    rst        = 1'b1;
    mrdy_ctl   = 4'hF;
    fixed_mode = 1'b0;

    // Reset values
    tick();
    for (int d = 0; d < 4; d++) begin
      check("rst_m_stb", {31'd0, m_stb[d]}, 32'd0);
      check("rst_m_dat", {24'd0, m_dat[d]}, 32'd0);
      check("rst_s_rdy", {28'd0, s_rdy[d]}, 32'd0);
      check("rst_state", {31'd0, dbg_st[d]}, {31'd0, IDLE});
    end
    rst = 1'b0;
    tick();

    // 1: traffic, then asynchronous reset mid-cycle, then idle
    begin_test(0);
    for (int k = 0; k < 20; k++) src_q.push_back(2'(k % 2));
    set_lim(0, 0, 100);
    set_lim(0, 1, 100);
    repeat (6) tick();
    check("t1_busy_m_stb", {31'd0, m_stb[0]}, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    stop_all();
    exp_q.delete();
    src_q.delete();
    #1;
    check("t1_async_m_stb", {31'd0, m_stb[0]}, 32'd0);
    check("t1_async_s_rdy", {28'd0, s_rdy[0]}, 32'd0);
    check("t1_async_m_dat", {24'd0, m_dat[0]}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t1_idle_m_stb", {31'd0, m_stb[0]}, 32'd0);
    end

    // 2: N=3 B=1 all requesting -> A0,B1,C2,A0,... one per cycle
    do_reset();
    fixed_mode = 1'b1;
    begin_test(1);
    for (int k = 0; k < 12; k++) src_q.push_back(2'(k % 3));
    for (int i = 0; i < 3; i++) set_lim(1, i, 4);
    wait_done(80);
    check_timing("t2", 11, 12);
    fixed_mode = 1'b0;

    // 3: N=2 B=4 both requesting -> bursts of 4, no bubble at switch
    do_reset();
    begin_test(2);
    for (int k = 0; k < 16; k++) src_q.push_back(2'((k / 4) % 2));
    set_lim(2, 0, 8);
    set_lim(2, 1, 8);
    wait_done(80);
    check_timing("t3", 15, 16);

    // 4: backpressure on a single stream, 8 beats in order
    do_reset();
    begin_test(0);
    base = seq[0][0];
    for (int k = 0; k < 8; k++) src_q.push_back(2'd0);
    set_lim(0, 0, 8);
    repeat (3) tick();
    check("t4_pre_m_stb", {31'd0, m_stb[0]}, 32'd1);
    mrdy_ctl[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_stall_m_stb", {31'd0, m_stb[0]}, 32'd1);
      check("t4_stall_s_rdy", {28'd0, s_rdy[0]}, 32'd0);
      check("t4_stall_m_dat", {24'd0, m_dat[0]}, {24'd0, 4'd0, 4'(base + 1)});
    end
    mrdy_ctl[0] = 1'b1;
    wait_done(60);
    check("t4_beats", 32'(bcnt), 32'd8);

    // 5a: B=4, slave 1 drops after 2 beats while slave 0 still requests
    do_reset();
    begin_test(2);
    for (int k = 0; k < 4; k++) src_q.push_back(2'd0);
    for (int k = 0; k < 2; k++) src_q.push_back(2'd1);
    for (int k = 0; k < 4; k++) src_q.push_back(2'd0);
    set_lim(2, 0, 8);
    set_lim(2, 1, 2);
    wait_done(80);
    check_timing("t5a", 10, 10);

    // 5b: B=4, sole requester keeps streaming across burst boundaries
    do_reset();
    begin_test(2);
    for (int k = 0; k < 9; k++) src_q.push_back(2'd0);
    set_lim(2, 0, 9);
    wait_done(60);
    check_timing("t5b", 8, 9);

    // 6: N=4, requests 1010 -> sources 1,3,1,3
    do_reset();
    begin_test(3);
    src_q.push_back(2'd1);
    src_q.push_back(2'd3);
    src_q.push_back(2'd1);
    src_q.push_back(2'd3);
    set_lim(3, 1, 2);
    set_lim(3, 3, 2);
    wait_done(60);
    check_timing("t6", 3, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
